inst_boot_loader: RTL and testbench

- Upstream stage of the single-cycle computer.
- Receives a program image as a byte stream over a valid/ready interface and writes it into instruction ROM, one 32-bit word at a time, through the ROM's write port.
- Holds the CPU in reset until the image has loaded and its checksum has verified.
- Image framing: 16-bit big-endian word count N, then N words (4 bytes each, MSB first), then one checksum byte.

---
 rtl/inst_boot_loader.sv | 122 ++++++++++++
 tb/tb_inst_boot_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_boot_loader.sv
// Byte-stream program loader: frames an image into instruction ROM words,
// verifies its XOR checksum and holds the CPU in reset until it passes.
module inst_boot_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       len;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        bidx;
  logic [7:0]        csum;
  logic [23:0]       asm_q;
  logic              accept;
  logic [15:0]       full_len;
  logic              last_word;

  assign byte_ready = state inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign accept     = byte_valid & byte_ready;
  assign full_len   = {len[15:8], byte_data};
  // 17-bit compare so a full 2^ADDR_W image never aliases to zero
  assign last_word  = (17'(widx) + 17'd1) == 17'(len);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      len       <= '0;
      widx      <= '0;
      bidx      <= '0;
      csum      <= '0;
      asm_q     <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            widx      <= '0;
            bidx      <= '0;
            csum      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            state     <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            csum      <= csum ^ byte_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            csum     <= csum ^ byte_data;
            if (17'(full_len) > CAP) begin
              state <= ERR;
              error <= 1'b1;
            end else if (full_len == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum  <= csum ^ byte_data;
            asm_q <= {asm_q[15:0], byte_data};
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              rom_we    <= 1'b1;
              rom_waddr <= widx;
              rom_wdata <= {asm_q, byte_data};
              widx      <= widx + 1'b1;
              if (last_word) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (byte_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Randomized bench for inst_boot_loader: images are built from a word list,
// and observed ROM writes are compared with that list and accept timing.
`timescale 1ns/1ps
module tb_inst_boot_loader;
  localparam int ADDR_W = 6;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int w_cyc[$];
  int w_addr[$];
  logic [31:0] w_data[$];
  int acc_q[$];
  logic [7:0]  img[$];
  logic [31:0] exp_w[$];
  bit tmo;

  inst_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .rom_we(rom_we),
    .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock)
    if (rom_we) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(int'(rom_waddr));
      w_data.push_back(rom_wdata);
    end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_words(input int n);
    exp_w = {};
    for (int i = 0; i < n; i++) exp_w.push_back($urandom);
  endtask

  // Image = 16-bit BE length, words MSB first, XOR of all prior bytes.
  task automatic build_image(input int n, input int csum_ovr);
    logic [7:0] x;
    img = {};
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    for (int i = 0; i < exp_w.size(); i++)
      for (int b = 3; b >= 0; b--) img.push_back(8'(exp_w[i] >> (8 * b)));
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    img.push_back(csum_ovr < 0 ? x : 8'(csum_ovr));
  endtask

  task automatic go();
    w_cyc = {}; w_addr = {}; w_data = {};
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic send(input int pct, input int max_bytes);
    int p, n, waited;
    bit v, rdy;
    p = 0; tmo = 0; waited = 0; acc_q = {};
    n = int'({img[0], img[1]});
    while (p < img.size() && p < max_bytes) begin
      v = ($urandom_range(99) < pct);
      byte_valid = v;
      byte_data  = v ? img[p] : 8'($urandom);
      rdy = byte_ready;
      if (v && rdy) begin
        if (p >= 2 && p < 2 + 4 * n && (p - 2) % 4 == 3)
          acc_q.push_back(cyc + 1);
        p++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 400) begin
          tmo = 1;
          break;
        end
      end
      @(negedge Clock);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    n_assert++;
    if ({cpu_reset, done, error, byte_ready, rom_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000",
               {cpu_reset, done, error, byte_ready, rom_we});
    end
    n_assert++;
    if (rom_waddr !== '0 || rom_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rom: got %h/%h want 0/0", rom_waddr, rom_wdata);
    end
    Reset = 1'b0;
    @(negedge Clock);
    n_assert++;
    if (byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready %b want 0", byte_ready);
    end
  endtask

  task automatic test_basic();
    exp_w = {32'h24080005, 32'h8C090004};
    build_image(2, -1);
    go();
    send(100, 1000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || w_addr.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d tmo %0d want 2", w_addr.size(), tmo);
    end
    for (int i = 0; i < w_addr.size() && i < 2; i++) begin
      n_assert++;
      if (w_addr[i] != i || w_data[i] !== exp_w[i] || w_cyc[i] != acc_q[i]) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got %0d/%h@%0d want %0d/%h@%0d", i,
                 w_addr[i], w_data[i], w_cyc[i], i, exp_w[i], acc_q[i]);
      end
    end
    n_assert++;
    if ({done, cpu_reset, error} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_done: got %b want 100", {done, cpu_reset, error});
    end
  endtask

  task automatic test_bad_csum();
    exp_w = {32'h24080005, 32'h8C090004};
    build_image(2, 8'h0E);
    go();
    send(100, 1000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || w_addr.size() != 2) begin
      n_fail++;
      $display("FAIL bad_count: got %0d tmo %0d want 2", w_addr.size(), tmo);
    end
    for (int i = 0; i < w_addr.size() && i < 2; i++) begin
      n_assert++;
      if (w_addr[i] != i || w_data[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL bad_wr%0d: got %0d/%h want %0d/%h", i,
                 w_addr[i], w_data[i], i, exp_w[i]);
      end
    end
    n_assert++;
    if ({error, done, cpu_reset, byte_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL bad_err: got %b want 1010",
               {error, done, cpu_reset, byte_ready});
    end
    build_image(2, -1);
    go();
    send(100, 1000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || {done, error, cpu_reset} !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_recover: got %b want 100", {done, error, cpu_reset});
    end
  endtask

  task automatic test_len_bounds();
    img = {8'h00, 8'h41};
    go();
    send(100, 2);
    n_assert++;
    if (tmo || error !== 1'b1 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL len_over: got err %b rdy %b want 1 0", error, byte_ready);
    end
    repeat (3) @(negedge Clock);
    n_assert++;
    if (w_addr.size() != 0 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL len_over_wr: got %0d writes want 0", w_addr.size());
    end
    exp_w = {};
    build_image(0, -1);
    go();
    send(100, 1000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || w_addr.size() != 0 || {done, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL len_zero: got %0d writes done %b err %b want 0 1 0",
               w_addr.size(), done, error);
    end
  endtask

  task automatic test_random_valid();
    rand_words(64);
    build_image(64, -1);
    go();
    send(50, 10000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || w_addr.size() != 64) begin
      n_fail++;
      $display("FAIL rand_count: got %0d tmo %0d want 64", w_addr.size(), tmo);
    end
    for (int i = 0; i < w_addr.size() && i < 64; i++) begin
      n_assert++;
      if (w_addr[i] != i || w_data[i] !== exp_w[i] || w_cyc[i] != acc_q[i]) begin
        n_fail++;
        $display("FAIL rand_wr%0d: got %0d/%h@%0d want %0d/%h@%0d", i,
                 w_addr[i], w_data[i], w_cyc[i], i, exp_w[i], acc_q[i]);
      end
    end
    n_assert++;
    if ({done, cpu_reset, error} !== 3'b100) begin
      n_fail++;
      $display("FAIL rand_done: got %b want 100", {done, cpu_reset, error});
    end
  endtask

  task automatic test_reset_midload();
    rand_words(3);
    build_image(3, -1);
    go();
    send(100, 8);
    Reset = 1'b1;
    @(negedge Clock);
    n_assert++;
    if ({cpu_reset, byte_ready, done, error, rom_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want 10000",
               {cpu_reset, byte_ready, done, error, rom_we});
    end
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    n_assert++;
    if (w_addr.size() != 1 || w_data[0] !== exp_w[0]) begin
      n_fail++;
      $display("FAIL mid_writes: got %0d want 1", w_addr.size());
    end
    go();
    send(100, 1000);
    repeat (3) @(negedge Clock);
    n_assert++;
    if (tmo || w_addr.size() != 3 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reload: got %0d writes done %b want 3 1",
               w_addr.size(), done);
    end
    for (int i = 0; i < w_addr.size() && i < 3; i++) begin
      n_assert++;
      if (w_addr[i] != i || w_data[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL mid_wr%0d: got %0d/%h want %0d/%h", i,
                 w_addr[i], w_data[i], i, exp_w[i]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_bounds();
    test_random_valid();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
